// File: rtl/complex_acc_dump_if.sv
// Sample-in / dump-out bundle of the complex integrate-and-dump stage.
// The producer side (upstream multiplier plus window control) is the master.
interface complex_acc_dump_if #(
    parameter int DIN_WIDTH  = 18,
    parameter int DOUT_WIDTH = 16
);
    logic                         clr;
    logic                         din_valid;
    logic signed [DIN_WIDTH-1:0]  din_i;
    logic signed [DIN_WIDTH-1:0]  din_q;
    logic                         dout_valid;
    logic signed [DOUT_WIDTH-1:0] dout_i;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic                         dout_sat;

    modport master (
        output clr, din_valid, din_i, din_q,
        input  dout_valid, dout_i, dout_q, dout_sat
    );

    modport slave (
        input  clr, din_valid, din_i, din_q,
        output dout_valid, dout_i, dout_q, dout_sat
    );
endinterface

// File: rtl/complex_acc_dump.sv
// Integrate-and-dump of ACC_LEN complex products per window, with a
// round-half-up shift and saturation on each dump; windows run back-to-back.
module complex_acc_dump #(
    parameter int DIN_WIDTH  = 18,
    parameter int ACC_LEN    = 16,
    parameter int SHIFT      = 4,
    parameter int DOUT_WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    complex_acc_dump_if.slave bus
);
    localparam int ACC_WIDTH = DIN_WIDTH + $clog2(ACC_LEN);
    localparam int CNT_WIDTH = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int RND_WIDTH = ACC_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACC_LEN - 1);

    // 2^(SHIFT-1), which collapses to zero when SHIFT is 0.
    localparam logic [RND_WIDTH:0]          RND_ONE  = {{RND_WIDTH{1'b0}}, 1'b1} << SHIFT;
    localparam logic signed [RND_WIDTH-1:0] RND_HALF = RND_ONE[RND_WIDTH:1];

    localparam logic signed [RND_WIDTH-1:0] SAT_MAX =
        {{(RND_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [RND_WIDTH-1:0] SAT_MIN =
        {{(RND_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
    localparam logic [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    logic [CNT_WIDTH-1:0]        cnt;
    logic signed [ACC_WIDTH-1:0] acc_i;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] hold_i;
    logic signed [ACC_WIDTH-1:0] hold_q;
    logic                        dump_pend;

    logic signed [ACC_WIDTH-1:0] din_i_ext;
    logic signed [ACC_WIDTH-1:0] din_q_ext;
    logic signed [ACC_WIDTH-1:0] sum_i;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic                        win_first;
    logic                        win_last;
    logic [DOUT_WIDTH:0]         res_i;
    logic [DOUT_WIDTH:0]         res_q;

    // Returns {saturated, value}.
    function automatic logic [DOUT_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] h);
        logic signed [RND_WIDTH-1:0] r;
        r = (RND_WIDTH'(h) + RND_HALF) >>> SHIFT;
        if (r > SAT_MAX)
            return {1'b1, DOUT_MAX};
        else if (r < SAT_MIN)
            return {1'b1, DOUT_MIN};
        else
            return {1'b0, r[DOUT_WIDTH-1:0]};
    endfunction

    assign din_i_ext = ACC_WIDTH'(bus.din_i);
    assign din_q_ext = ACC_WIDTH'(bus.din_q);
    assign win_first = (cnt == '0);
    assign win_last  = (cnt == CNT_LAST);

    // The first sample of a window loads rather than adds, so windows abut.
    always_comb begin
        sum_i = din_i_ext;
        sum_q = din_q_ext;
        if (!win_first) begin
            sum_i = acc_i + din_i_ext;
            sum_q = acc_q + din_q_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            hold_i    <= '0;
            hold_q    <= '0;
            dump_pend <= 1'b0;
        end else begin
            dump_pend <= 1'b0;
            if (bus.clr) begin
                cnt <= '0;
            end else if (bus.din_valid) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                if (win_last) begin
                    cnt       <= '0;
                    hold_i    <= sum_i;
                    hold_q    <= sum_q;
                    dump_pend <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        res_i = round_sat(hold_i);
        res_q = round_sat(hold_q);
    end

    // Output registers hold the last dump; clr never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout_valid <= 1'b0;
            bus.dout_i     <= '0;
            bus.dout_q     <= '0;
            bus.dout_sat   <= 1'b0;
        end else begin
            bus.dout_valid <= dump_pend;
            if (dump_pend) begin
                bus.dout_i   <= res_i[DOUT_WIDTH-1:0];
                bus.dout_q   <= res_q[DOUT_WIDTH-1:0];
                bus.dout_sat <= res_i[DOUT_WIDTH] | res_q[DOUT_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_complex_acc_dump.sv
// Directed bench for complex_acc_dump with a queue scoreboard; ACC_LEN=4, SHIFT=2, DOUT_WIDTH=8.
module tb_complex_acc_dump;
    localparam int DW = 18;
    localparam int OW = 8;

    typedef struct {
        logic signed [OW-1:0] i;
        logic signed [OW-1:0] q;
        logic                 sat;
        int                   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    logic rst_q;
    bit   mon_en = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    exp_t sb[$];
    logic signed [OW-1:0] last_i = '0;
    logic signed [OW-1:0] last_q = '0;
    logic                 last_s = 1'b0;

    complex_acc_dump_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

    complex_acc_dump #(
        .DIN_WIDTH (DW),
        .ACC_LEN   (4),
        .SHIFT     (2),
        .DOUT_WIDTH(OW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Monitor: pops on every pulse, otherwise checks outputs hold the last dump.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) begin
                last_i = '0;
                last_q = '0;
                last_s = 1'b0;
            end
            compared++;
            if (bus.dout_valid) begin
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL spurious_pulse cyc=%0d got i=%0d q=%0d sat=%0b, no dump expected",
                             cyc, bus.dout_i, bus.dout_q, bus.dout_sat);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.dout_i !== e.i || bus.dout_q !== e.q ||
                        bus.dout_sat !== e.sat || cyc != e.cyc) begin
                        mismatched++;
                        $display("FAIL dump got i=%0d q=%0d sat=%0b cyc=%0d, want i=%0d q=%0d sat=%0b cyc=%0d",
                                 bus.dout_i, bus.dout_q, bus.dout_sat, cyc, e.i, e.q, e.sat, e.cyc);
                    end
                    last_i = e.i;
                    last_q = e.q;
                    last_s = e.sat;
                end
            end else if (bus.dout_i !== last_i || bus.dout_q !== last_q || bus.dout_sat !== last_s) begin
                mismatched++;
                $display("FAIL hold cyc=%0d got i=%0d q=%0d sat=%0b, want i=%0d q=%0d sat=%0b",
                         cyc, bus.dout_i, bus.dout_q, bus.dout_sat, last_i, last_q, last_s);
            end
        end
    end

    task automatic drive(input int i, input int q, input bit v, input bit c);
        @(posedge clk);
        #1;
        bus.din_valid = v;
        bus.clr       = c;
        bus.din_i     = DW'(i);
        bus.din_q     = DW'(q);
    endtask

    // A dump expected from the sample just driven shows up two cycles later.
    task automatic expect_dump(input int ei, input int eq, input bit es);
        exp_t e;
        e.i   = OW'(ei);
        e.q   = OW'(eq);
        e.sat = es;
        e.cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic window(input int a[4], input int b[4], input int ei, input int eq, input bit es);
        for (int k = 0; k < 4; k++) begin
            drive(a[k], b[k], 1'b1, 1'b0);
            if (k == 3) expect_dump(ei, eq, es);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int acc_cnt;
        bus.clr       = 1'b0;
        bus.din_valid = 1'b1;
        bus.din_i     = DW'($urandom);
        bus.din_q     = DW'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            mon_en    = 1'b1;
            bus.din_i = DW'($urandom);
            bus.din_q = DW'($urandom);
        end
        rst           = 1'b0;
        bus.din_valid = 1'b0;

        // basic
        window('{10, 20, 30, 40}, '{-10, -20, -30, -40}, 25, -25, 1'b0);
        idle(3);

        // rounding: I sums 6, 5, -6, -7 with Q = -I
        window('{1, 2, 1, 2},     '{-1, -2, -1, -2}, 2, -1, 1'b0);
        window('{2, 1, 1, 1},     '{-2, -1, -1, -1}, 1, -1, 1'b0);
        window('{-1, -2, -3, 0},  '{1, 2, 3, 0},    -1,  2, 1'b0);
        window('{-4, -1, -1, -1}, '{4, 1, 1, 1},    -2,  2, 1'b0);
        idle(2);

        // saturation then recovery
        window('{1000, 1000, 1000, 1000}, '{-1000, -1000, -1000, -1000}, 127, -128, 1'b1);
        window('{4, 4, 4, 4}, '{4, 4, 4, 4}, 4, 4, 1'b0);
        idle(2);

        // gaps then back-to-back
        acc_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (k < 12 && (k % 3) == 1) idle(1);
            drive(4, 4, 1'b1, 1'b0);
            acc_cnt++;
            if ((acc_cnt % 4) == 0) expect_dump(4, 4, 1'b0);
        end
        idle(3);

        // clr drops the partial window and the coincident sample
        drive(100, 100, 1'b1, 1'b0);
        drive(100, 100, 1'b1, 1'b0);
        drive(100, 100, 1'b1, 1'b1);
        window('{4, 4, 4, 4}, '{4, 4, 4, 4}, 4, 4, 1'b0);

        // clr right after a window's last sample keeps that dump
        window('{8, 8, 8, 8}, '{8, 8, 8, 8}, 8, 8, 1'b0);
        drive(100, 100, 1'b1, 1'b1);
        window('{4, 4, 4, 4}, '{4, 4, 4, 4}, 4, 4, 1'b0);
        idle(6);

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL missing_dumps got %0d dumps still pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
